// File: rtl/slot_reels_if.sv
// rtl/slot_reels_if.sv - spin request and reel result signals between slot_fsm and slot_reels
interface slot_reels_if;
  logic            slotRunning;
  logic [2:0][3:0] slotNums;
  logic [2:0]      reelsMoving;
  logic            settled;

  // Game FSM side: requests spins, observes the reels
  modport master (
    output slotRunning,
    input  slotNums,
    input  reelsMoving,
    input  settled
  );

  // Reel generator side
  modport slave (
    input  slotRunning,
    output slotNums,
    output reelsMoving,
    output settled
  );
endinterface

// File: rtl/slot_reels.sv
// rtl/slot_reels.sv - three staggered-stop reel digit generators; optional SLOT_JITTER_EN adds LFSR step jitter
module slot_reels #(
  parameter int DIV0    = 2,
  parameter int DIV1    = 3,
  parameter int DIV2    = 5,
  parameter int STAGGER = 8
) (
  input  logic        clk,
  input  logic        rst,
  slot_reels_if.slave bus
);

  // Stagger counter holds STAGGER-1 down to 0, so one stop phase lasts STAGGER cycles.
  localparam int SW = (STAGGER > 1) ? $clog2(STAGGER) : 1;
  localparam logic [SW-1:0] STAG_LOAD = SW'(STAGGER - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SPIN  = 3'd1,
    STOP1 = 3'd2,
    STOP2 = 3'd3,
    DONE  = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   stag_q, stag_d;
  logic            presc_clr;
  logic [2:0]      moving;
  logic [2:0]      step_inc;
  logic [2:0][3:0] nums;

  // FSM state and stagger counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      stag_q  <= '0;
    end else begin
      state_q <= state_d;
      stag_q  <= stag_d;
    end
  end

  // Next-state logic; a respin request always wins over stagger expiry
  always_comb begin
    state_d   = state_q;
    stag_d    = stag_q;
    presc_clr = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.slotRunning) begin
          state_d   = SPIN;
          presc_clr = 1'b1;
        end
      end
      SPIN: begin
        if (!bus.slotRunning) begin
          state_d = STOP1;
          stag_d  = STAG_LOAD;
        end
      end
      STOP1: begin
        if (bus.slotRunning) begin
          state_d = SPIN;
        end else if (stag_q == '0) begin
          state_d = STOP2;
          stag_d  = STAG_LOAD;
        end else begin
          stag_d = stag_q - 1'b1;
        end
      end
      STOP2: begin
        if (bus.slotRunning) begin
          state_d = SPIN;
        end else if (stag_q == '0) begin
          state_d = DONE;
        end else begin
          stag_d = stag_q - 1'b1;
        end
      end
      DONE: begin
        // A spin request here is deliberately dropped; IDLE picks it up next edge.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Decode which reels may step from the registered state
  always_comb begin
    moving = 3'b000;
    case (state_q)
      SPIN:    moving = 3'b111;
      STOP1:   moving = 3'b110;
      STOP2:   moving = 3'b100;
      default: moving = 3'b000;
    endcase
  end

`ifdef SLOT_JITTER_EN
  logic [15:0] lfsr_q;

  // Free-running Galois LFSR, x^16+x^14+x^13+x^11+1
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= {1'b0, lfsr_q[15:1]} ^ ({16{lfsr_q[0]}} & 16'hB400);
    end
  end

  // Step size of 1..4 drawn from the low LFSR bits
  always_comb begin
    step_inc = {1'b0, lfsr_q[1:0]} + 3'd1;
  end
`else
  // Plain counting reels advance by one per step
  always_comb begin
    step_inc = 3'd1;
  end
`endif

  for (genvar g = 0; g < 3; g++) begin : g_reel
    localparam int DIV = (g == 0) ? DIV0 : ((g == 1) ? DIV1 : DIV2);
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] WRAP = PW'(DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    digit_q, digit_d;
    logic [4:0]    sum;
    logic          step;

    // Prescaler advance and modulo-10 digit step for this reel
    always_comb begin
      step    = moving[g] && (presc_q == WRAP);
      presc_d = presc_q;
      if (presc_clr) begin
        presc_d = '0;
      end else if (moving[g]) begin
        presc_d = step ? '0 : presc_q + 1'b1;
      end
      sum     = {1'b0, digit_q} + {2'b00, step_inc};
      digit_d = digit_q;
      if (step) begin
        digit_d = (sum >= 5'd10) ? 4'(sum - 5'd10) : sum[3:0];
      end
    end

    // Prescaler and digit registers; both hold while the reel is frozen
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        presc_q <= '0;
        digit_q <= '0;
      end else begin
        presc_q <= presc_d;
        digit_q <= digit_d;
      end
    end

    assign nums[g] = digit_q;
  end

  assign bus.slotNums    = nums;
  assign bus.reelsMoving = moving;
  assign bus.settled     = (state_q == DONE);

endmodule
